// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage pipelined barrel shifter (SLL/SRL/SRA/ROL)
// with valid/ready handshakes on both sides and a passthrough tag.
// Right shifts reuse the single left-shift network by reversing the
// operand on the way in and the result on the way out.
`timescale 1ns/1ps
module shift_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // Reverse bit order so right shifts can run through the left-shift network.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q;
  logic [SHW-1:0]   s1_shamt_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_zero_q;

  // Handshake / control
  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic s2_load;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  // A flush discards any transfer presented in the same cycle.
  assign accept   = in_valid && s1_adv && !flush;
  assign s2_load  = s1_valid_q && s2_adv && !flush;

  // Shifter datapath between S1 and S2
  logic             right_mode;
  logic             rot_mode;
  logic             fill_bit;
  logic [WIDTH-1:0] lvl [SHW+1];
  logic [WIDTH-1:0] shift_res;
  logic             res_zero;

  assign right_mode = (s1_op_q == OP_SRL) || (s1_op_q == OP_SRA);
  assign rot_mode   = (s1_op_q == OP_ROL);
  assign fill_bit   = (s1_op_q == OP_SRA) && s1_data_q[WIDTH-1];
  assign lvl[0]     = right_mode ? bit_rev(s1_data_q) : s1_data_q;

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int SH = 1 << k;
    logic [SH-1:0] low_bits;
    // Rotate recirculates the bits leaving the MSB; otherwise shift in the fill.
    assign low_bits   = rot_mode ? lvl[k][WIDTH-1 -: SH] : {SH{fill_bit}};
    assign lvl[k+1]   = s1_shamt_q[k] ? {lvl[k][WIDTH-1-SH:0], low_bits} : lvl[k];
  end

  assign shift_res = right_mode ? bit_rev(lvl[SHW]) : lvl[SHW];
  assign res_zero  = (shift_res == {WIDTH{1'b0}});

  // Next-state of the stage valid bits; flush empties both stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
      end else begin
        s2_valid_d = s2_valid_q;
      end
      if (s1_adv) begin
        s1_valid_d = in_valid;
      end else begin
        s1_valid_d = s1_valid_q;
      end
    end
  end

  // Valid-bit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1 payload capture on an accepted input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q  <= {WIDTH{1'b0}};
      s1_shamt_q <= {SHW{1'b0}};
      s1_op_q    <= OP_SLL;
      s1_tag_q   <= {TAG_W{1'b0}};
    end else if (accept) begin
      s1_data_q  <= in_data;
      s1_shamt_q <= in_shamt;
      s1_op_q    <= in_op;
      s1_tag_q   <= in_tag;
    end
  end

  // Stage 2 result capture; holds stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data_q <= {WIDTH{1'b0}};
      s2_tag_q  <= {TAG_W{1'b0}};
      s2_zero_q <= 1'b1;
    end else if (s2_load) begin
      s2_data_q <= shift_res;
      s2_tag_q  <= s1_tag_q;
      s2_zero_q <= res_zero;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign out_zero  = s2_zero_q;

endmodule
